// File: rtl/writeback_regfile_pkg.sv
// writeback_regfile_pkg: shared pipeline widths, zero-register index and the MEM/WB register layout
package writeback_regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } memwb_t;
endpackage

// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: MEM-side inputs, hazard controls, decode read ports and WB forwarding outputs
// master: pipeline side (drives mem_*, stall, flush, ra1/ra2; observes data*R and wb_*)
// slave:  write-back stage (consumes the above, produces data1R/data2R and wb_valid/wb_we/wb_dest/wb_data)
interface writeback_regfile_if;
    import writeback_regfile_pkg::*;
    logic              mem_valid;
    logic              mem_regwrite;
    logic              mem_memtoreg;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_alu;
    logic [ADDR_W-1:0] mem_dest;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] data1R;
    logic [DATA_W-1:0] data2R;
    logic              wb_valid;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    modport master (
        output mem_valid, mem_regwrite, mem_memtoreg, mem_rdata, mem_alu, mem_dest,
               stall, flush, ra1, ra2,
        input  data1R, data2R, wb_valid, wb_we, wb_dest, wb_data
    );
    modport slave (
        input  mem_valid, mem_regwrite, mem_memtoreg, mem_rdata, mem_alu, mem_dest,
               stall, flush, ra1, ra2,
        output data1R, data2R, wb_valid, wb_we, wb_dest, wb_data
    );
endinterface

// File: rtl/writeback_regfile_regfile_2r1w.sv
// regfile_2r1w: register array with one write port, two combinational read ports with write bypass, async clear
// ports: clk, rst_n (async active-low clear), we/waddr/wdata (write), ra1/ra2 -> rd1/rd2 (reads)
module regfile_2r1w
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = writeback_regfile_pkg::DATA_W,
    parameter int ADDR_W = writeback_regfile_pkg::ADDR_W,
    parameter int NREGS  = writeback_regfile_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && waddr != REG_ZERO) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // the write being committed this cycle is returned ahead of storage
    always_comb begin
        rd1 = (ra1 == REG_ZERO) ? '0 : (we && waddr == ra1) ? wdata : regs_q[ra1];
        rd2 = (ra2 == REG_ZERO) ? '0 : (we && waddr == ra2) ? wdata : regs_q[ra2];
    end
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: MEM/WB pipeline register, write-data select, and the general-purpose register file
// ports: clk, rst_n (async active-low), bus (writeback_regfile_if.slave: mem_* inputs, stall/flush,
//        ra1/ra2 -> data1R/data2R, registered wb_valid/wb_we/wb_dest/wb_data)
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = writeback_regfile_pkg::DATA_W,
    parameter int ADDR_W = writeback_regfile_pkg::ADDR_W,
    parameter int NREGS  = writeback_regfile_pkg::NREGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    writeback_regfile_if.slave    bus
);
    memwb_t wb_q;
    memwb_t wb_d;

    // flush beats stall; r0 never raises a write so the bypass cannot leak into $0
    always_comb begin
        wb_d = bus.flush ? '0 : bus.stall ? wb_q : '{
            valid: bus.mem_valid,
            we:    bus.mem_valid & bus.mem_regwrite & (bus.mem_dest != REG_ZERO),
            dest:  bus.mem_dest,
            data:  bus.mem_memtoreg ? bus.mem_rdata : bus.mem_alu
        };
    end

    // async clear drops any pending write, so nothing commits on the reset edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_q <= '0;
        else        wb_q <= wb_d;
    end

    assign bus.wb_valid = wb_q.valid;
    assign bus.wb_we    = wb_q.we;
    assign bus.wb_dest  = wb_q.dest;
    assign bus.wb_data  = wb_q.data;

    regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_q.we),
        .waddr (wb_q.dest),
        .wdata (wb_q.data),
        .ra1   (bus.ra1),
        .ra2   (bus.ra2),
        .rd1   (bus.data1R),
        .rd2   (bus.data2R)
    );
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed self-checking bench for the write-back register file
module tb_writeback_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    writeback_regfile_if bus();

    writeback_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.mem_valid = 0; bus.mem_regwrite = 0; bus.mem_memtoreg = 0;
        bus.mem_rdata = '0; bus.mem_alu = '0; bus.mem_dest = '0;
        bus.stall = 0; bus.flush = 0; bus.ra1 = '0; bus.ra2 = '0;
        tick(); tick();
        chk("por_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("por_data1R", bus.data1R, 32'd0);
        rst_n = 1'b1;
        tick();
        // reset with a pending write to r7
        bus.mem_valid = 1; bus.mem_regwrite = 1; bus.mem_alu = 32'd77; bus.mem_dest = 5'd7; bus.ra1 = 5'd7;
        tick();
        chk("pend_wb_we", {31'd0, bus.wb_we}, 32'd1);
        chk("pend_bypass", bus.data1R, 32'd77);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("rst_wb_dest", {27'd0, bus.wb_dest}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_data1R", bus.data1R, 32'd0);
        bus.mem_valid = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_r7", bus.data1R, 32'd0);
        // ALU write to r9: bypass, then storage
        bus.mem_valid = 1; bus.mem_regwrite = 1; bus.mem_memtoreg = 0;
        bus.mem_alu = 32'hDEADBEEF; bus.mem_dest = 5'd9; bus.ra1 = 5'd9;
        tick();
        chk("alu_wb_we", {31'd0, bus.wb_we}, 32'd1);
        chk("alu_bypass", bus.data1R, 32'hDEADBEEF);
        bus.mem_valid = 0;
        tick();
        chk("alu_wb_we_off", {31'd0, bus.wb_we}, 32'd0);
        chk("alu_stored", bus.data1R, 32'hDEADBEEF);
        // load select aimed at $0
        bus.mem_valid = 1; bus.mem_memtoreg = 1; bus.mem_rdata = 32'h12345678; bus.mem_alu = 32'h0;
        bus.mem_dest = 5'd0; bus.ra1 = 5'd0; bus.ra2 = 5'd0;
        tick();
        chk("r0_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("r0_wb_data", bus.wb_data, 32'h12345678);
        chk("r0_byp_d1", bus.data1R, 32'd0);
        chk("r0_byp_d2", bus.data2R, 32'd0);
        bus.mem_valid = 0;
        tick();
        chk("r0_st_d1", bus.data1R, 32'd0);
        chk("r0_st_d2", bus.data2R, 32'd0);
        // load select to a real register
        bus.mem_valid = 1; bus.mem_dest = 5'd10; bus.mem_alu = 32'hFFFF0000; bus.ra2 = 5'd10;
        tick();
        chk("load_bypass", bus.data2R, 32'h12345678);
        bus.mem_valid = 0; bus.mem_memtoreg = 0;
        tick();
        chk("load_stored", bus.data2R, 32'h12345678);
        // flush on the same edge as a write to r3
        bus.mem_valid = 1; bus.mem_alu = 32'hA5A5A5A5; bus.mem_dest = 5'd3; bus.ra1 = 5'd3; bus.flush = 1;
        tick();
        chk("flush_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("flush_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("flush_bypass", bus.data1R, 32'd0);
        bus.flush = 0; bus.mem_valid = 0;
        tick();
        chk("flush_r3", bus.data1R, 32'd0);
        // stall holds r4 write, then flush overrides stall
        bus.mem_valid = 1; bus.mem_alu = 32'h11; bus.mem_dest = 5'd4; bus.ra1 = 5'd4; bus.ra2 = 5'd6;
        tick();
        chk("st_wb_data0", bus.wb_data, 32'h11);
        bus.stall = 1;
        for (int k = 0; k < 3; k++) begin
            bus.mem_alu = 32'h99 + k; bus.mem_dest = 5'd6;
            tick();
            chk("st_wb_data", bus.wb_data, 32'h11);
            chk("st_wb_dest", {27'd0, bus.wb_dest}, 32'd4);
            chk("st_r4", bus.data1R, 32'h11);
            chk("st_r6", bus.data2R, 32'd0);
        end
        bus.flush = 1;
        tick();
        chk("sf_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("sf_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("sf_r4", bus.data1R, 32'h11);
        bus.stall = 0; bus.flush = 0; bus.mem_valid = 0;
        tick();
        chk("sf_r6", bus.data2R, 32'd0);
        // back-to-back writes to r5, dual read
        bus.mem_valid = 1; bus.mem_alu = 32'd1; bus.mem_dest = 5'd5; bus.ra1 = 5'd5; bus.ra2 = 5'd5;
        tick();
        chk("b2b1_d1", bus.data1R, 32'd1);
        chk("b2b1_d2", bus.data2R, 32'd1);
        bus.mem_alu = 32'd2;
        tick();
        chk("b2b2_d1", bus.data1R, 32'd2);
        chk("b2b2_d2", bus.data2R, 32'd2);
        bus.mem_valid = 0;
        tick();
        chk("b2b_st_d1", bus.data1R, 32'd2);
        chk("b2b_st_d2", bus.data2R, 32'd2);
        bus.ra1 = 5'd9; bus.ra2 = 5'd4;
        #1;
        chk("final_r9", bus.data1R, 32'hDEADBEEF);
        chk("final_r4", bus.data2R, 32'h11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
